muldiv_unit: RTL and testbench

//  Iterative unsigned multiply/divide unit for the datapath's M-extension ops. Takes operands

---
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative unsigned multiply / divide unit for the M-extension ops.
//   Operands arrive from the regfile read ports. A shift-add multiply or a
//   restoring divide then runs for DATA_WIDTH cycles. The unit ends with a
//   one-cycle write strobe (we/rd/d) into the regfile write port.
//
//   Ports
//     clk    : clock, all state updates on the rising edge
//     rst_n  : asynchronous active-low reset, aborts any op in flight
//     start  : request, sampled only while busy=0
//     op     : 00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU
//     a      : multiplicand / dividend
//     b      : multiplier / divisor
//     rd_in  : destination register for this op
//     busy   : op in flight (through the done cycle), start ignored
//     done   : one-cycle result strobe
//     we     : regfile write enable (done with rd != 0)
//     rd     : regfile write address, latched at start
//     d      : result; valid with done, otherwise holds the last result
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  op,
  input  logic [DATA_WIDTH-1:0]       a,
  input  logic [DATA_WIDTH-1:0]       b,
  input  logic [$clog2(NUM_REGS)-1:0] rd_in,
  output logic                        busy,
  output logic                        done,
  output logic                        we,
  output logic [$clog2(NUM_REGS)-1:0] rd,
  output logic [DATA_WIDTH-1:0]       d
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     op_q;
  logic [W-1:0]   x_q;     // multiplicand (MUL*) or divisor (DIV*)
  logic [W-1:0]   hi_q;    // product high half / partial remainder
  logic [W-1:0]   lo_q;    // multiplier shifting out, product low half / quotient
  logic [CW-1:0]  cnt_q;
  logic           dz_q;    // divide by zero: skip iterations, force result

  logic           accept;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_fit;
  logic [W-1:0]   hi_nxt, lo_nxt;
  logic [W-1:0]   result;

  // Busy stays high through the done cycle, so a start there is dropped.
  assign accept = start && !busy && (state_q == IDLE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (op[1] && (b == '0)) ? DONE : RUN;
      RUN:  if (cnt_q == CW'(W - 1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One iteration of the datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // Multiply: add the multiplicand into the high half when the multiplier
    // LSB is set, then shift the whole {carry, hi, lo} right by one.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, x_q} : '0);
    // Divide: shift {rem, quot} left by one, then trial-subtract the divisor.
    div_shift = {hi_q, lo_q[W-1]};
    div_fit   = (div_shift >= {1'b0, x_q});
    div_diff  = div_shift - {1'b0, x_q};

    if (op_q[1]) begin
      hi_nxt = div_fit ? div_diff[W-1:0] : div_shift[W-1:0];
      lo_nxt = {lo_q[W-2:0], div_fit};
    end else begin
      hi_nxt = mul_sum[W:1];
      lo_nxt = {mul_sum[0], lo_q[W-1:1]};
    end
  end

  always_comb begin
    unique case (op_q)
      2'b00:   result = lo_q;
      2'b01:   result = hi_q;
      2'b10:   result = dz_q ? '1 : lo_q;
      default: result = hi_q;   // REMU; with dz_q, hi_q was loaded with a
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      x_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      we      <= 1'b0;
      rd      <= '0;
      d       <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == DONE);
      we      <= (state_q == DONE) && (rd != '0);

      if (accept) begin
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= op;
            x_q   <= op[1] ? b : a;
            lo_q  <= op[1] ? a : b;
            // A zero divisor skips the iterations. Preload a so REMU
            // returns the dividend without a separate result path.
            hi_q  <= (op[1] && (b == '0)) ? a : '0;
            cnt_q <= '0;
            dz_q  <= op[1] && (b == '0);
            rd    <= rd_in;
          end
        end
        RUN: begin
          hi_q  <= hi_nxt;
          lo_q  <= lo_nxt;
          cnt_q <= cnt_q + CW'(1);
        end
        DONE: begin
          d <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit (DATA_WIDTH=32, NUM_REGS=32).
//   Every issued op pushes its expected write-back onto a queue. A monitor
//   pops that queue on each done strobe and compares d/we/rd. The scenario
//   tasks also check latency, busy/done framing, ignored starts and abort.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W  = 32;
  localparam int NR = 32;

  typedef struct {
    logic [W-1:0] d;
    logic [4:0]   rd;
    logic         we;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [4:0]    rd_in;
  logic          busy;
  logic          done;
  logic          we;
  logic [4:0]    rd;
  logic [W-1:0]  d;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  muldiv_unit #(.DATA_WIDTH(W), .NUM_REGS(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .rd_in (rd_in),
    .busy  (busy),
    .done  (done),
    .we    (we),
    .rd    (rd),
    .d     (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built on 64-bit arithmetic.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (y == '0) ? {W{1'b1}} : x / y;
      default: return (y == '0) ? x : x % y;
    endcase
  endfunction

  // Scoreboard monitor: compares every done strobe against the oldest
  // expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_done: got d=%h rd=%0d, expected no result", d, rd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (d !== e.d || we !== e.we || rd !== e.rd)
          $display("FAIL sb_result: got d=%h we=%b rd=%0d, expected d=%h we=%b rd=%0d",
                   d, we, rd, e.d, e.we, e.rd);
        else
          n_pass++;
      end
    end
  end

  // Drives one request so that the next rising edge is the start edge E0.
  // Returns #1 after E0 with start released.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [4:0] r);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; rd_in = r;
    e.d = model(o, x, y); e.rd = r; e.we = (r != 5'd0);
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts rising edges after E0 until done is seen; -1 when the bound expires.
  task automatic wait_done(output int edges);
    bit seen;
    seen  = 1'b0;
    edges = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) edges = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy, done, we, rd, d} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b rd=%0d d=%h, expected all 0",
               busy, done, we, rd, d);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul;
    int e;
    issue(2'b00, 32'd7, 32'd6, 5'd5);
    n_total++;
    if (busy !== 1'b1) $display("FAIL mul_busy_after_start: got %b, expected 1", busy);
    else n_pass++;
    wait_done(e);
    n_total++;
    if (e != 33) $display("FAIL mul_latency: got %0d edges, expected 33", e);
    else n_pass++;
    n_total++;
    if (busy !== 1'b1 || we !== 1'b1)
      $display("FAIL mul_done_cycle: got busy=%b we=%b, expected busy=1 we=1", busy, we);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0 || we !== 1'b0)
      $display("FAIL mul_after_done: got done=%b busy=%b we=%b, expected 0 0 0", done, busy, we);
    else n_pass++;
    n_total++;
    if (d !== 32'd42) $display("FAIL mul_d_hold: got %h, expected 0000002a", d);
    else n_pass++;
  endtask

  task automatic test_mul_wide;
    int e;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    wait_done(e);
    n_total++;
    if (e != 33) $display("FAIL mulhu_latency: got %0d, expected 33", e);
    else n_pass++;
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    wait_done(e);
    n_total++;
    if (e != 33) $display("FAIL mul_wide_latency: got %0d, expected 33", e);
    else n_pass++;
  endtask

  task automatic test_div;
    int e;
    issue(2'b10, 32'd100, 32'd7, 5'd9);
    wait_done(e);
    issue(2'b11, 32'd100, 32'd7, 5'd10);
    wait_done(e);
    issue(2'b10, 32'hFFFF_FFFF, 32'd1, 5'd11);
    wait_done(e);
    n_total++;
    if (e != 33) $display("FAIL div_latency: got %0d, expected 33", e);
    else n_pass++;
  endtask

  task automatic test_div_zero;
    int e;
    issue(2'b10, 32'd9, 32'd0, 5'd12);
    wait_done(e);
    n_total++;
    if (e != 1) $display("FAIL divz_latency: got %0d, expected 1", e);
    else n_pass++;
    issue(2'b11, 32'd9, 32'd0, 5'd13);
    wait_done(e);
    n_total++;
    if (e != 1) $display("FAIL remz_latency: got %0d, expected 1", e);
    else n_pass++;
  endtask

  // Starts during the run and during the done cycle must be dropped.
  task automatic test_ignored_start;
    int dones;
    int e;
    issue(2'b00, 32'd5, 32'd11, 5'd3);
    dones = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      start = (c == 5 || c == 20 || c == 34);
      op = 2'b10; a = 32'd1; b = 32'd0; rd_in = 5'd4;
    end
    start = 1'b0;
    n_total++;
    if (dones != 1) $display("FAIL ignored_start_dones: got %0d, expected 1", dones);
    else n_pass++;
    // rd_in = 0 still completes but never writes x0.
    issue(2'b00, 32'd4, 32'd4, 5'd0);
    wait_done(e);
    n_total++;
    if (e != 33 || we !== 1'b0)
      $display("FAIL rd0_no_write: got latency=%0d we=%b, expected 33 0", e, we);
    else n_pass++;
  endtask

  task automatic test_abort;
    int dones;
    int e;
    issue(2'b10, 32'd1000, 32'd3, 5'd7);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    n_total++;
    if ({busy, done, we, d} !== '0)
      $display("FAIL abort_outputs: got busy=%b done=%b we=%b d=%h, expected 0", busy, done, we, d);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    n_total++;
    if (dones != 0) $display("FAIL abort_no_done: got %0d dones, expected 0", dones);
    else n_pass++;
    issue(2'b00, 32'd3, 32'd3, 5'd2);
    wait_done(e);
    n_total++;
    if (e != 33) $display("FAIL post_abort_latency: got %0d, expected 33", e);
    else n_pass++;
  endtask

  // Random ops issued back-to-back as soon as busy drops.
  task automatic test_back_to_back;
    int e;
    int lat;
    logic [1:0]   o;
    logic [W-1:0] x, y;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom();
      y = (i == 5) ? 32'd0 : ((i % 2 == 0) ? $urandom() : 32'($urandom_range(1, 1000)));
      issue(o, x, y, 5'($urandom_range(0, 31)));
      lat = (o[1] && y == '0) ? 1 : 33;
      wait_done(e);
      n_total++;
      if (e != lat) $display("FAIL b2b_latency_%0d: got %0d, expected %0d", i, e, lat);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_wide();
    test_div();
    test_div_zero();
    test_ignored_start();
    test_abort();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_drained: got %0d pending, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
